// File: rtl/clk_gate_sequencer.sv
// ============================================================================
// Module   : clk_gate_sequencer
// Purpose  : Controls a bank of per-domain clock-gating cells. A domain's gate
//            enable is raised on request and dropped after a programmable run
//            of idle cycles. All enable edges (on and off) are funnelled
//            through one round-robin sequencer with a guard interval, so at
//            most one gate toggles per STAGGER_CYCLES window.
// Ports    : clk_i          - clock, all logic on the rising edge
//            rst_i          - synchronous reset, active high
//            req_i          - per-domain clock request (level)
//            idle_i         - per-domain idle indication (level)
//            idle_timeout_i - idle cycles required before gate-off
//            test_mode_i    - forces every enable on (outputs only)
//            en_o           - gate enable per clock-gate cell
//            ack_o          - domain clock running and usable
//            busy_o         - a domain is pending or the guard is running
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_gate_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int IDLE_CNT_W     = 8,
  parameter int STAGGER_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_DOMAINS-1:0] req_i,
  input  logic [NUM_DOMAINS-1:0] idle_i,
  input  logic [IDLE_CNT_W-1:0]  idle_timeout_i,
  input  logic                   test_mode_i,
  output logic [NUM_DOMAINS-1:0] en_o,
  output logic [NUM_DOMAINS-1:0] ack_o,
  output logic                   busy_o
);

  localparam int RR_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int GUARD_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(STAGGER_CYCLES - 1);
  localparam logic [RR_W-1:0]    RR_LAST    = RR_W'(NUM_DOMAINS - 1);
  localparam logic [RR_W:0]      RR_WRAP    = (RR_W+1)'(NUM_DOMAINS);

  localparam logic [1:0] ST_OFF      = 2'd0;
  localparam logic [1:0] ST_PEND_ON  = 2'd1;
  localparam logic [1:0] ST_ON       = 2'd2;
  localparam logic [1:0] ST_PEND_OFF = 2'd3;

  logic [NUM_DOMAINS-1:0] pend_req;   // pending and still wanted this cycle
  logic [NUM_DOMAINS-1:0] pend_any;   // in a pending state (for busy_o)
  logic [NUM_DOMAINS-1:0] grant;
  logic [NUM_DOMAINS-1:0] en_vec;
  logic [NUM_DOMAINS-1:0] ack_vec;

  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [RR_W-1:0]    rr_q, rr_d;

  // --------------------------------------------------------------------------
  // Per-domain FSM and idle counter
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
    logic [1:0]            state_q, state_d;
    logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  en_q, en_d;
    logic                  ack_q, ack_d;
    logic [IDLE_CNT_W:0]   cnt_inc;
    logic                  cnt_hit;
    logic                  idle_ok;

    assign idle_ok = ~req_i[i] & idle_i[i];
    assign cnt_inc = {1'b0, cnt_q} + {{IDLE_CNT_W{1'b0}}, 1'b1};
    // The cycle being counted now completes the run; >= also covers a
    // timeout lowered below the current count.
    assign cnt_hit = cnt_inc >= {1'b0, idle_timeout_i};

    // Pending requests are qualified with this cycle's inputs so a domain
    // cancelling now can never be granted.
    assign pend_req[i] = ((state_q == ST_PEND_ON)  & req_i[i]) |
                         ((state_q == ST_PEND_OFF) & idle_ok);
    assign pend_any[i] = (state_q == ST_PEND_ON) | (state_q == ST_PEND_OFF);
    assign en_vec[i]   = en_q;
    assign ack_vec[i]  = ack_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        ack_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        en_q    <= en_d;
        ack_q   <= ack_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      case (state_q)
        ST_OFF: begin
          if (req_i[i]) state_d = ST_PEND_ON;
        end
        ST_PEND_ON: begin
          if (!req_i[i]) begin
            state_d = ST_OFF;
          end else if (grant[i]) begin
            state_d = ST_ON;
            en_d    = 1'b1;
            cnt_d   = '0;
          end
        end
        ST_ON: begin
          if (!idle_ok) begin
            cnt_d = '0;
          end else if (cnt_hit) begin
            state_d = ST_PEND_OFF;
            cnt_d   = idle_timeout_i;
          end else begin
            cnt_d = cnt_inc[IDLE_CNT_W-1:0];
          end
        end
        ST_PEND_OFF: begin
          if (!idle_ok) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else if (grant[i]) begin
            state_d = ST_OFF;
            en_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_OFF;
          en_d    = 1'b0;
          cnt_d   = '0;
        end
      endcase
      // Ack lags a rising enable by one cycle but follows a falling one.
      ack_d = en_q & en_d;
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin sequencer with guard interval
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      guard_q <= '0;
      rr_q    <= '0;
    end else begin
      guard_q <= guard_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    logic [RR_W:0]   cand_sum;
    logic [RR_W-1:0] cand;
    logic            found;
    grant    = '0;
    rr_d     = rr_q;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    if (guard_q == '0) begin
      for (int k = 0; k < NUM_DOMAINS; k++) begin
        cand_sum = {1'b0, rr_q} + (RR_W+1)'(k);
        if (cand_sum >= RR_WRAP) cand_sum = cand_sum - RR_WRAP;
        cand = cand_sum[RR_W-1:0];
        if (!found && pend_req[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          rr_d        = (cand == RR_LAST) ? '0 : cand + RR_W'(1);
        end
      end
    end
    if (found)              guard_d = GUARD_LOAD;
    else if (guard_q != '0) guard_d = guard_q - GUARD_W'(1);
    else                    guard_d = guard_q;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    en_o   = en_vec | {NUM_DOMAINS{test_mode_i}};
    ack_o  = ack_vec;
    busy_o = (|pend_any) | (guard_q != '0);
  end

endmodule

`default_nettype wire
